// File: rtl/mux8_arb_pkg.sv
// rtl/mux8_arb_pkg.sv - shared state type, sizes and round-robin pick function for mux8_rr_arbiter
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    // Walk from ptr (searched last) back towards ptr+1 so the nearest requester overwrites.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux8_rr_pick.sv
// rtl/mux8_rr_pick.sv - combinational rotate/priority-encode over 8 requests
// MUX8_ARB_PRIO_EN: requester 0 wins any arbitration and leaves the pointer untouched.
module mux8_rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_upd_ptr
);

  pick_t w_rr;

  assign w_rr = rr_pick(i_req, i_ptr);

`ifdef MUX8_ARB_PRIO_EN
  always_comb begin
    o_found   = w_rr.found;
    o_idx     = w_rr.idx;
    o_upd_ptr = 1'b1;
    if (i_req[0]) begin
      o_idx     = '0;
      o_upd_ptr = 1'b0;
    end
  end
`else
  assign o_found   = w_rr.found;
  assign o_idx     = w_rr.idx;
  assign o_upd_ptr = 1'b1;
`endif

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin owner of the mux_8x1 select with burst-limited grants
// MUX8_ARB_PRIO_EN (in mux8_rr_pick) makes requester 0 high priority.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_withdraw;
  logic             w_beat;
  logic             w_release;
  logic [N_REQ-1:0] w_pick_req;
  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic             w_upd_ptr;

  assign out_valid  = (r_state == GRANT) && req[r_sel];
  assign w_beat     = out_valid && out_ready;
  assign w_withdraw = (r_state == GRANT) && !req[r_sel];
  assign w_release  = w_withdraw || (w_beat && (r_cnt == LAST_BEAT));
  // A withdrawing grantee must not win its own re-arbitration; r_gnt is zero in IDLE.
  assign w_pick_req = w_withdraw ? (req & ~r_gnt) : req;

  mux8_rr_pick u_pick (
    .i_req     (w_pick_req),
    .i_ptr     (r_ptr),
    .o_found   (w_found),
    .o_idx     (w_idx),
    .o_upd_ptr (w_upd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= SEL_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_idx;
          w_gnt_nxt   = N_REQ'(1) << w_idx;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          if (w_upd_ptr) w_ptr_nxt = w_idx;
        end
      end
      GRANT: begin
        if (w_release) begin
          if (w_found) begin
            w_sel_nxt = w_idx;
            w_gnt_nxt = N_REQ'(1) << w_idx;
            w_cnt_nxt = '0;
            if (w_upd_ptr) w_ptr_nxt = w_idx;
          end else begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = '0;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign sel      = r_sel;
  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign beat_cnt = r_cnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed and random checks of mux8_rr_arbiter against a behavioural model
module tb_mux8_rr_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic       busy;
  logic [3:0] beat_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  bit m_busy = 1'b0;
  int m_sel  = 0;
  int m_cnt  = 0;
  int m_ptr  = 7;

  mux8_rr_arbiter #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Winner is the first requester after p going upward modulo 8; returns 0 when nobody asks.
  function automatic bit model_pick(input logic [7:0] r, input int p, output int w, output int np);
    w  = 0;
    np = p;
`ifdef MUX8_ARB_PRIO_EN
    if (r[0]) return 1'b1;
`endif
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) begin
        w  = (p + k) % 8;
        np = w;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int         w, np;
    bit         rearb;
    logic [7:0] cand;
    if (rst) begin
      m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_ptr = 7;
    end else if (!m_busy) begin
      if (model_pick(req, m_ptr, w, np)) begin
        m_busy = 1'b1; m_sel = w; m_cnt = 0; m_ptr = np;
      end
    end else begin
      rearb = 1'b0;
      cand  = req;
      if (!req[m_sel]) begin
        rearb = 1'b1;
        cand[m_sel] = 1'b0;
      end else if (out_ready) begin
        if (m_cnt == MAXB - 1) rearb = 1'b1;
        else m_cnt++;
      end
      if (rearb) begin
        if (model_pick(cand, m_ptr, w, np)) begin
          m_sel = w; m_cnt = 0; m_ptr = np;
        end else begin
          m_busy = 1'b0; m_sel = 0; m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", int'(sel), m_sel);
      check("gnt", int'(gnt), m_busy ? (1 << m_sel) : 0);
      check("busy", int'(busy), int'(m_busy));
      check("beat_cnt", int'(beat_cnt), m_cnt);
      check("out_valid", int'(out_valid), int'(m_busy && req[m_sel]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    check("rst_sel", int'(sel), 0);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(beat_cnt), 0);
    rst = 1'b0;

    req = 8'h01;
    tick();
    check("t1_gnt", int'(gnt), 8'h01);
    check("t1_sel", int'(sel), 0);
    out_ready = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("t1_cnt", int'(beat_cnt), e % 4);
      check("t1_regnt", int'(gnt), 8'h01);
    end

    do_reset();
    req = 8'h88; out_ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("t2_sel", int'(sel), (((e - 1) / 4) % 2 == 1) ? 7 : 3);
      check("t2_busy", int'(busy), 1);
    end

    do_reset();
    req = 8'h24; out_ready = 1'b1;
    tick();
    check("t3_sel2", int'(sel), 2);
    tick();
    tick();
    check("t3_cnt2", int'(beat_cnt), 2);
    req = 8'h20;
    tick();
    check("t3_sel5", int'(sel), 5);
    check("t3_gnt", int'(gnt), 8'h20);
    check("t3_cnt0", int'(beat_cnt), 0);

    do_reset();
    req = 8'h01; out_ready = 1'b0;
    tick();
    for (int e = 0; e < 10; e++) begin
      tick();
      check("t4_hold_cnt", int'(beat_cnt), 0);
      check("t4_hold_gnt", int'(gnt), 8'h01);
    end
    out_ready = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("t4_cnt", int'(beat_cnt), e % 4);
    end

    do_reset();
    req = 8'h40; out_ready = 1'b1;
    tick();
    tick();
    check("t5_sel6", int'(sel), 6);
    rst = 1'b1; req = 8'hFF;
    tick();
    check("t5_rst_gnt", int'(gnt), 0);
    check("t5_rst_sel", int'(sel), 0);
    check("t5_rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    check("t5_first_sel", int'(sel), 0);
    check("t5_first_gnt", int'(gnt), 8'h01);

    do_reset();
    req = 8'h11; out_ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
`ifdef MUX8_ARB_PRIO_EN
      check("t6_prio_sel", int'(sel), 0);
`else
      check("t6_rr_sel", int'(sel), (((e - 1) / 4) % 2 == 1) ? 4 : 0);
`endif
    end

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: req = 8'h00;
          1: req = 8'h01 << $urandom_range(7);
          default: req = 8'($urandom);
        endcase
      end
      out_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(149) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
